// File: rtl/program_sequencer_stk.sv
// Program sequencer: generates the next program-memory address each cycle with
// sequential fetch, jumps, hardware call/return via a LIFO return stack, and fetch hold.
module program_sequencer_stk #(
    parameter int              PC_W         = 8,
    parameter int              STACK_DEPTH  = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    localparam int             SP_W         = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic            jmp,
    input  logic            jmp_nz,
    input  logic            dont_jmp,
    input  logic            call,
    input  logic            ret,
    input  logic            hold,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [SP_W-1:0] sp,
    output logic            stack_overflow,
    output logic            stack_underflow
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [PC_W-1:0]  stack_q [STACK_DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic             push_en;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Strobes are evaluated strictly by priority; a lower-priority strobe
    // asserted with a higher one has no side effects at all.
    always_comb begin
        pc_inc  = pc_q + PC_W'(1);
        rd_idx  = IDX_W'(sp_q - SP_W'(1));
        wr_idx  = IDX_W'(sp_q);
        pc_d    = pc_inc;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        if (sync_reset) begin
            pc_d  = RESET_VECTOR;
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (hold) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (sp_q != '0) begin
                pc_d = stack_q[rd_idx];
                sp_d = sp_q - SP_W'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (call) begin
            pc_d = target;
            if (sp_q < SP_W'(STACK_DEPTH)) begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    assign pm_addr         = pc_d;
    assign pc              = pc_q;
    assign sp              = sp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer_stk.sv
// Self-checking bench for program_sequencer_stk: directed test-plan steps followed by
// random strobes, compared against a queue-based behavioural model.
module tb_program_sequencer_stk;

    localparam int        PC_W  = 8;
    localparam int        DEPTH = 4;
    localparam logic [7:0] RV   = 8'h00;
    localparam int        SP_W  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            sync_reset = 1'b1;
    logic            jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0;
    logic            call = 1'b0, ret = 1'b0, hold = 1'b0;
    logic [PC_W-1:0] target = '0;
    logic [PC_W-1:0] pm_addr, pc;
    logic [SP_W-1:0] sp;
    logic            stack_overflow, stack_underflow;

    int errors = 0;
    int checks = 0;
    int stepno = 0;

    int m_pc = 0;
    int m_stack[$];
    int m_ovf = 0;
    int m_unf = 0;

    always #5 clk = ~clk;

    program_sequencer_stk #(
        .PC_W(PC_W),
        .STACK_DEPTH(DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk(clk),
        .sync_reset(sync_reset),
        .jmp(jmp),
        .jmp_nz(jmp_nz),
        .dont_jmp(dont_jmp),
        .call(call),
        .ret(ret),
        .hold(hold),
        .target(target),
        .pm_addr(pm_addr),
        .pc(pc),
        .sp(sp),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed=%0h expected=%0h", tag, stepno, obs, exp);
        end
    endtask

    // One clock cycle: drive strobes, check combinational pm_addr, clock, check state.
    task automatic step(input bit r, input bit h, input bit rt, input bit cl,
                        input bit j, input bit jn, input bit dz, input int tg);
        int inc;
        int exp_pm;
        stepno++;
        sync_reset = r; hold = h; ret = rt; call = cl;
        jmp = j; jmp_nz = jn; dont_jmp = dz; target = tg[PC_W-1:0];
        inc = (m_pc + 1) % (1 << PC_W);
        if (r) begin
            exp_pm = int'(RV);
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (h) begin
            exp_pm = m_pc;
        end else if (rt) begin
            if (m_stack.size() > 0) exp_pm = m_stack.pop_back();
            else begin
                exp_pm = inc;
                m_unf = 1;
            end
        end else if (cl) begin
            exp_pm = tg % (1 << PC_W);
            if (m_stack.size() < DEPTH) m_stack.push_back(inc);
            else m_ovf = 1;
        end else if (j || (jn && !dz)) begin
            exp_pm = tg % (1 << PC_W);
        end else begin
            exp_pm = inc;
        end
        #3;
        chk("pm_addr", 32'(pm_addr), exp_pm);
        m_pc = exp_pm;
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), m_pc);
        chk("sp", 32'(sp), m_stack.size());
        chk("ovf", 32'(stack_overflow), m_ovf);
        chk("unf", 32'(stack_underflow), m_unf);
    endtask

    task automatic nop();     step(0, 0, 0, 0, 0, 0, 0, 0);  endtask
    task automatic rst();     step(1, 0, 0, 0, 0, 0, 0, 0);  endtask
    task automatic jump(input int t); step(0, 0, 0, 0, 1, 0, 0, t); endtask
    task automatic callto(input int t); step(0, 0, 0, 1, 0, 0, 0, t); endtask
    task automatic retn();    step(0, 0, 1, 0, 0, 0, 0, 0);  endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset and free run through the wrap.
        rst();
        for (int i = 0; i < 256; i++) nop();
        chk("wrap_pc0", 32'(pc), 0);

        // Jumps
        jump(8'h10);
        jump(8'h40);
        nop();
        step(0, 0, 0, 0, 0, 1, 1, 8'h99);
        chk("jnz_not_taken", 32'(pc), 8'h42);
        step(0, 0, 0, 0, 0, 1, 0, 8'h80);
        chk("jnz_taken", 32'(pc), 8'h80);

        // Nested call/ret
        jump(8'h05);
        callto(8'h20);
        nop();
        callto(8'h30);
        retn();
        chk("ret_inner", 32'(pc), 8'h22);
        retn();
        chk("ret_outer", 32'(pc), 8'h06);

        // Overflow then underflow
        for (int i = 0; i < 5; i++) callto(8'h50);
        chk("ovf_set", 32'(stack_overflow), 1);
        for (int i = 0; i < 5; i++) retn();
        chk("unf_set", 32'(stack_underflow), 1);
        for (int i = 0; i < 3; i++) nop();

        // Hold and priority
        rst();
        jump(8'h33);
        step(0, 1, 0, 1, 0, 0, 0, 8'h70);
        step(0, 0, 0, 1, 1, 0, 0, 8'h70);
        chk("prio_sp", 32'(sp), 1);
        step(0, 0, 1, 1, 0, 0, 0, 8'h60);
        chk("ret_over_call", 32'(pc), 8'h34);

        // Call from all-ones pushes 0; back-to-back call/ret
        jump(8'hFF);
        callto(8'h10);
        retn();
        chk("wrap_push", 32'(pc), 0);

        // Reset mid-subroutine
        callto(8'h11); callto(8'h22); callto(8'h33);
        rst();
        retn();

        // Random strobes
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/program_sequencer_stk.md
Name: program_sequencer_stk

Overview:
Parametrised next-generation program sequencer for the micro core. It generates the program-memory address every cycle and supports the following:
- sequential fetch, unconditional jump and conditional jump
- hardware subroutine call/return through an internal LIFO return stack of configurable depth
- a fetch-hold (stall) input

It sits between the instruction decoder (control strobes, target address) and program memory (pm_addr). It replaces the fixed 8-bit, jump-only sequencer.

Parameters:
PC_W, 8, width of program counter and program-memory address
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VECTOR, 0, address presented on pm_addr during reset

Ports:
clk  input  1  system clock; all state updates on rising edge
sync_reset  input  1  synchronous, active-high reset
jmp  input  1  unconditional jump strobe
jmp_nz  input  1  conditional jump strobe; taken when dont_jmp=0
dont_jmp  input  1  zero flag from computational unit; suppresses jmp_nz
call  input  1  push return address, jump to target
ret  input  1  pop return address, jump to it
hold  input  1  stall: re-present current pc, no state change
target  input  PC_W  jump/call destination address
pm_addr  output  PC_W  program-memory address (combinational next-pc)
pc  output  PC_W  registered program counter
sp  output  clog2(STACK_DEPTH+1)  number of valid stack entries
stack_overflow  output  1  sticky: call attempted with stack full
stack_underflow  output  1  sticky: ret attempted with stack empty

Behaviour:
Clocking and reset
- Single clock domain.
- pc <= pm_addr on every rising edge. pm_addr is combinational from pc, the strobes and stack state, with zero latency.
- sync_reset=1: pm_addr=RESET_VECTOR, so pc=RESET_VECTOR after the edge. It also sets sp=0, stack_overflow=0 and stack_underflow=0.
- Stack entry storage is not reset.

pm_addr selection (priority, highest first)
1. sync_reset: RESET_VECTOR.
2. hold: pc. No push/pop; sp and flags unchanged.
3. ret: if sp>0, stack[sp-1] and sp decrements. If sp=0, pc+1 (ret acts as NOP) and stack_underflow sets.
4. call: always target. If sp<STACK_DEPTH, stack[sp] <= pc+1 and sp increments. If sp=STACK_DEPTH, the push is discarded, sp is unchanged and stack_overflow sets (redirect still taken).
5. jmp: target.
6. jmp_nz and dont_jmp=0: target.
7. Otherwise: pc+1.

Arithmetic and flags
- pc+1 is modulo 2^PC_W: all-ones wraps to 0.
- The pushed return address (pc+1) wraps identically.
- Lower-priority strobes asserted together with a higher one are ignored entirely: no push, pop or flag side effects.
- stack_overflow and stack_underflow are cleared only by sync_reset.
- sp is never outside 0..STACK_DEPTH.

Boundary cases
- Back-to-back call/ret in consecutive cycles is legal. A ret immediately after a call returns to the call address +1.
- A call from address 2^PC_W-1 pushes 0.
- Reset asserted mid-subroutine discards the stack (sp=0). Execution restarts at RESET_VECTOR.

Test Plan:
1. Reset then free run, PC_W=8: sync_reset 1 cycle -> pm_addr=0 during reset, then pc steps 0,1,2,...,255,0. Wrap verified; sp=0, both flags 0.
2. Jumps, pc=0x10: jmp with target=0x40 -> next pc=0x40. At pc=0x41, jmp_nz with dont_jmp=1 -> pc=0x42. jmp_nz with dont_jmp=0 and target=0x80 -> pc=0x80.
3. Nested call/ret, STACK_DEPTH=4:
   - call at 0x05 to 0x20 -> sp=1.
   - call at 0x21 to 0x30 -> sp=2.
   - ret -> pc=0x22, sp=1.
   - ret -> pc=0x06, sp=0. No flags.
4. Overflow/underflow:
   - 5 calls, each to target 0x50 -> 5th call still jumps to 0x50, sp stays 4, stack_overflow=1.
   - 4 rets return to the pushed addresses.
   - 5th ret -> pc+1 taken, stack_underflow=1.
   - Both flags persist until sync_reset.
5. Hold and priority:
   - hold with call asserted at pc=0x33 -> pm_addr=0x33; sp and flags unchanged.
   - Release hold with call+jmp, target=0x70 -> pc=0x70 and exactly one push of 0x34.
   - ret+call together with sp=1 -> pop only, sp=0.
6. Reset mid-operation: sp=3, then sync_reset -> pc=RESET_VECTOR, sp=0. A following ret raises stack_underflow.
